// File: rtl/desc_sample_addr_gen_pkg.sv
// Shared types and helpers for the SIFT descriptor sample address generator.
package desc_sample_addr_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_LAST = 2'd2
   } state_t;

   localparam int GRID_N = 256;

   // Grid index is {row[3:0], col[3:0]}; the 4x4 histogram cell is {row[3:2], col[3:2]}.
   function automatic logic [3:0] cell_of(input logic [7:0] idx);
      return {idx[7:6], idx[3:2]};
   endfunction

endpackage

// File: rtl/desc_oob_check.sv
// One-axis sample coordinate: signed add of the rotated offset to the keypoint centre,
// range check against [0, LIM) and clamp to 0 when out of range.
module desc_oob_check #(
   parameter int W   = 10,
   parameter int LIM = 640
) (
   input  logic [W-1:0] base,
   input  logic [4:0]   off,
   output logic [W-1:0] coord,
   output logic         oob
);

   logic signed [W+1:0] sum;

   // Two guard bits keep both the negative and the >= LIM results representable.
   assign sum   = $signed({2'b00, base}) + $signed({{(W-3){off[4]}}, off});
   assign oob   = sum[W+1] | (sum >= $signed((W+2)'(LIM)));
   assign coord = oob ? '0 : sum[W-1:0];

endmodule

// File: rtl/desc_sample_addr_gen.sv
// Descriptor sample address generator: sweeps the 16x16 grid per keypoint and emits
// bounds-checked sample coordinates. Optional macro DESC_OOB_SKIP_EN drops OOB samples (except idx 255).
//
// state   | meaning
// IDLE    | waiting for a keypoint; kp_ready high
// RUN     | sweeping idx 0..255 through the rotation ROM
// LAST    | idx 255 loaded; waiting for its acceptance
module desc_sample_addr_gen
   import desc_sample_addr_gen_pkg::*;
#(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int XW    = 10,
   parameter int YW    = 9,
   parameter int DW    = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          kp_valid,
   output logic          kp_ready,
   input  logic [XW-1:0] kp_x,
   input  logic [YW-1:0] kp_y,
   input  logic [DW-1:0] kp_dir,
   output logic [DW-1:0] rom_dir,
   output logic [7:0]    rom_a,
   input  logic [4:0]    rom_dx,
   input  logic [4:0]    rom_dy,
   output logic          smp_valid,
   input  logic          smp_ready,
   output logic [XW-1:0] smp_x,
   output logic [YW-1:0] smp_y,
   output logic [7:0]    smp_idx,
   output logic [3:0]    smp_cell,
   output logic          smp_oob,
   output logic          smp_last
);

   state_t        state, state_nxt;
   logic [XW-1:0] kx;
   logic [YW-1:0] ky;
   logic [DW-1:0] kdir;
   logic [7:0]    idx;
   logic [XW-1:0] cx;
   logic [YW-1:0] cy;
   logic          x_oob, y_oob, oob;
   logic          hs, load, emit, idx_end, accept_last;

   desc_oob_check #(.W(XW), .LIM(IMG_W)) u_chk_x (
      .base  (kx),
      .off   (rom_dx),
      .coord (cx),
      .oob   (x_oob)
   );

   desc_oob_check #(.W(YW), .LIM(IMG_H)) u_chk_y (
      .base  (ky),
      .off   (rom_dy),
      .coord (cy),
      .oob   (y_oob)
   );

   assign oob         = x_oob | y_oob;
   assign kp_ready    = (state == ST_IDLE);
   assign hs          = kp_valid & kp_ready;
   assign rom_a       = idx;
   assign rom_dir     = kdir;
   assign idx_end     = (idx == 8'(GRID_N - 1));
   assign load        = (state == ST_RUN) & (~smp_valid | smp_ready);
   assign accept_last = smp_valid & smp_ready & smp_last;

`ifdef DESC_OOB_SKIP_EN
   // idx 255 always goes out so every keypoint terminates with smp_last.
   assign emit = ~oob | idx_end;
`else
   assign emit = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (hs) state_nxt = ST_RUN;
         ST_RUN:  if (load && idx_end) state_nxt = ST_LAST;
         ST_LAST: if (accept_last) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kx   <= '0;
         ky   <= '0;
         kdir <= '0;
         idx  <= '0;
      end else if (hs) begin
         kx   <= kp_x;
         ky   <= kp_y;
         kdir <= kp_dir;
         idx  <= '0;
      end else if (load && !idx_end) begin
         idx  <= idx + 8'd1;
      end
   end

   // Output register: loads in RUN when free, otherwise drains on acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         smp_valid <= 1'b0;
         smp_x     <= '0;
         smp_y     <= '0;
         smp_idx   <= '0;
         smp_cell  <= '0;
         smp_oob   <= 1'b0;
         smp_last  <= 1'b0;
      end else if (load) begin
         smp_valid <= emit;
         if (emit) begin
            smp_x    <= oob ? '0 : cx;
            smp_y    <= oob ? '0 : cy;
            smp_idx  <= idx;
            smp_cell <= cell_of(idx);
            smp_oob  <= oob;
            smp_last <= idx_end;
         end
      end else if (smp_ready) begin
         smp_valid <= 1'b0;
      end
   end

endmodule
